sysbus_line_arbiter: RTL
========================

# sysbus_line_arbiter

Parametrised N-client Sysbus arbiter that moves whole cache lines between clients (I-cache, D-cache, later prefetch/DMA) and memory over the 64-bit Sysbus. It has one outstanding transaction at a time and supports line reads and line writes. Each transaction carries the client index in the request tag. Completion is decided by a beat count, never by `respcyc` dropping. It sits between the cache blocks and the top-level Sysbus and replaces the two-client fixed-priority arbiter.

## Interface
Parameters:
- `NCLIENT`, 2: number of clients, 2..8.
- `LINE_BITS`, 512: line size in bits; must be a multiple of `BUS_BITS`.
- `BUS_BITS`, 64: Sysbus data width.
- `BEATS`, derived: `LINE_BITS/BUS_BITS`.

Ports:
- `clk` in 1: clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `creq` in `NCLIENT`: per-client request.
- `cwr` in `NCLIENT`: per-client write flag.
- `caddr` in `NCLIENT*64`: per-client line address; client i uses `[i*64+:64]`.
- `cwdata` in `NCLIENT*LINE_BITS`: per-client write line.
- `crdata` out `LINE_BITS`: read line, shared by all clients.
- `cdone` out `NCLIENT`: per-client one-cycle completion pulse.
- `bus_req` out 64: Sysbus address or write data.
- `bus_reqtag` out 13: `{wr[12], type[11:8], owner[7:0]}`.
- `bus_reqcyc` out 1: Sysbus request valid.
- `bus_reqack` in 1: Sysbus request accepted.
- `bus_resp` in 64: Sysbus read data.
- `bus_resptag` in 13: Sysbus response tag.
- `bus_respcyc` in 1: Sysbus response valid.
- `bus_respack` out 1: Sysbus response accept.

## Operation
- States: IDLE, ADDR, WDATA, RWAIT, DONE.
- IDLE:
  - With any `creq` bit set, choose a grant index `g`.
  - Latch `caddr[g]`, `cwr[g]` and `cwdata[g]`.
  - Clear the beat counter.
  - Go to ADDR.
- ADDR:
  - Drive `bus_reqcyc=1`, `bus_req=addr`, `bus_reqtag={wr, MEMORY, 8'(g)}`.
  - Hold these until `bus_reqack` is high.
  - On ack: go to WDATA if `wr`, otherwise go to RWAIT.
- WDATA:
  - Drive `bus_reqcyc=1` and `bus_req = wbuf[k*64+:64]` for beat k = 0..BEATS-1, lowest word first, one beat per cycle.
  - After the last beat, go to DONE.
- RWAIT:
  - `bus_respack = bus_respcyc`, combinationally.
  - On each `bus_respcyc` whose `bus_resptag[7:0]==g`, store the beat in `rbuf[k*64+:64]` and increment k.
  - Responses with a mismatched tag are acked and discarded.
  - When k reaches BEATS, go to DONE.
- DONE:
  - `cdone[g]=1` for exactly one cycle.
  - On a read, `crdata` is loaded with the completed line. It holds that value until the next read completes.
  - `bus_reqcyc=0`. Next state is IDLE.
- `creq` is sampled only in IDLE. A client still asserting `creq` in the cycle after `cdone` is granted a new transaction.
- Beat counter width is `$clog2(BEATS+1)`. It is never allowed to wrap.
- `bus_respcyc` outside RWAIT is acked and ignored; no state change.

## Timing
- Reset values:
  - State IDLE.
  - `bus_reqcyc`, `bus_req`, `bus_reqtag`, `cdone` all 0.
  - `crdata` 0.
  - Round-robin pointer 0.
- Reset takes effect mid-transaction. The bus drops to idle the next cycle and no `cdone` is issued.
- Latency from `creq` to `bus_reqcyc`: 2 edges. The IDLE→ADDR edge is followed by registered outputs.
- A write with immediate ack takes BEATS+3 cycles from grant to `cdone`.
- A read takes the bus response latency plus 2 cycles.
- At least one IDLE cycle separates consecutive transactions.
- Simultaneous requests are resolved by the arbitration policy (see Configuration). The decision is made in a single cycle.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Search starts at `(last_grant+1) mod NCLIENT`; the first set `creq` wins.
  - The pointer updates at each grant.
  - No client waits more than NCLIENT-1 transactions.
- Undefined: fixed priority, lowest index wins (index 0 = D-cache). The pointer logic is absent.

## Test plan
- Read, client 1, `addr=0x1000`, bus returns words `0x0..0x7` with tag owner 1 → `bus_reqtag=0x0001` (wr=0, type 0, owner 1), `crdata[63:0]=0`, `crdata[511:448]=7`, `cdone=2'b10` for one cycle.
- Write, client 0, line words `0xA0..0xA7`, ack after 3 cycles → `bus_reqcyc` high for 3+8 cycles, beats `0xA0`→`0xA7` in order, then `cdone[0]` pulse.
- Both clients hold `creq` for 4 transactions:
  - With `ARB_ROUND_ROBIN_EN`, grants are 0,1,0,1.
  - Without it, grants are 0,0,0,0.
- Read response with tag owner 3 while `g=1` → beat discarded, counter unchanged, `bus_respack=1`; completion still needs 8 matching beats.
- `reset` asserted after beat 4 of a read → next cycle `bus_reqcyc=0`, no `cdone`; a new request afterwards completes normally.
- `bus_respcyc` pulse in IDLE → no state change, no `cdone`.

Source files
------------

// File: rtl/sysbus_line_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_line_arbiter_if
// Description : Client-side and Sysbus-side signal bundle for the line arbiter.
//               The master modport is the arbiter's view; the slave modport is
//               the surrounding clients plus the memory side of the bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface sysbus_line_arbiter_if #(
    parameter int NCLIENT   = 2,
    parameter int LINE_BITS = 512,
    parameter int BUS_BITS  = 64
);
    logic [NCLIENT-1:0]           creq;
    logic [NCLIENT-1:0]           cwr;
    logic [NCLIENT*64-1:0]        caddr;
    logic [NCLIENT*LINE_BITS-1:0] cwdata;
    logic [LINE_BITS-1:0]         crdata;
    logic [NCLIENT-1:0]           cdone;
    logic [BUS_BITS-1:0]          bus_req;
    logic [12:0]                  bus_reqtag;
    logic                         bus_reqcyc;
    logic                         bus_reqack;
    logic [BUS_BITS-1:0]          bus_resp;
    logic [12:0]                  bus_resptag;
    logic                         bus_respcyc;
    logic                         bus_respack;

    modport master (
        input  creq, cwr, caddr, cwdata,
        input  bus_reqack, bus_resp, bus_resptag, bus_respcyc,
        output crdata, cdone,
        output bus_req, bus_reqtag, bus_reqcyc, bus_respack
    );

    modport slave (
        output creq, cwr, caddr, cwdata,
        output bus_reqack, bus_resp, bus_resptag, bus_respcyc,
        input  crdata, cdone,
        input  bus_req, bus_reqtag, bus_reqcyc, bus_respack
    );
endinterface
`default_nettype wire

// File: rtl/sysbus_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_line_arbiter
// Description : N-client whole-line Sysbus arbiter, one outstanding transfer.
//               Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the
//               default build uses fixed priority (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module sysbus_line_arbiter #(
    parameter int NCLIENT   = 2,
    parameter int LINE_BITS = 512,
    parameter int BUS_BITS  = 64
) (
    input  wire logic             clk,
    input  wire logic             reset,
    sysbus_line_arbiter_if.master bus
);
    localparam int BEATS = LINE_BITS / BUS_BITS;
    localparam int c_CW  = $clog2(BEATS + 1);
    localparam int c_IW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int c_GW  = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
    localparam logic [3:0]      c_TYPE_MEMORY = 4'h0;
    localparam logic [c_CW-1:0] c_BEATS       = c_CW'(BEATS);
    localparam logic [c_CW-1:0] c_LAST        = c_CW'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_RWAIT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef logic [BEATS-1:0][BUS_BITS-1:0] line_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [c_GW-1:0]                 r_grant;
    logic [c_GW-1:0]                 w_grant;
    logic                            w_any_req;
    logic                            r_wr;
    logic [63:0]                     r_addr;
    line_t                           r_wbuf;
    line_t                           r_rbuf;
    line_t                           w_rbuf_next;
    logic [LINE_BITS-1:0]            r_crdata;
    logic [c_CW-1:0]                 r_beat;
    logic [c_CW-1:0]                 w_beat_next;
    logic [c_IW-1:0]                 w_beat_idx;
    logic                            r_bus_reqcyc;
    logic                            w_bus_reqcyc_next;
    logic [BUS_BITS-1:0]             r_bus_req;
    logic [BUS_BITS-1:0]             w_bus_req_next;
    logic [12:0]                     r_bus_reqtag;
    logic [12:0]                     w_bus_reqtag_next;
    logic [12:0]                     w_tag;
    logic [NCLIENT-1:0]              r_cdone;
    logic [NCLIENT-1:0]              w_cdone_next;
    logic [NCLIENT-1:0]              w_grant_onehot;
    logic                            w_req_fire;
    logic                            w_beat_take;
    logic                            w_line_done;
    logic [NCLIENT-1:0][63:0]        w_caddr_arr;
    logic [NCLIENT-1:0][LINE_BITS-1:0] w_cwdata_arr;
    logic                            w_unused_tag;

    assign w_caddr_arr    = bus.caddr;
    assign w_cwdata_arr   = bus.cwdata;
    assign w_any_req      = |bus.creq;
    assign w_beat_idx     = r_beat[c_IW-1:0];
    assign w_tag          = {r_wr, c_TYPE_MEMORY, 8'(r_grant)};
    assign w_grant_onehot = NCLIENT'(1) << r_grant;
    // A request transfer only counts once our own registered reqcyc is visible.
    assign w_req_fire     = r_bus_reqcyc & bus.bus_reqack;
    assign w_beat_take    = (r_state == S_RWAIT) && bus.bus_respcyc &&
                            (bus.bus_resptag[7:0] == 8'(r_grant));
    assign w_line_done    = w_beat_take && (r_beat == c_LAST);
    assign w_unused_tag   = ^bus.bus_resptag[12:8];

    assign bus.bus_req     = r_bus_req;
    assign bus.bus_reqtag  = r_bus_reqtag;
    assign bus.bus_reqcyc  = r_bus_reqcyc;
    assign bus.bus_respack = bus.bus_respcyc;
    assign bus.crdata      = r_crdata;
    assign bus.cdone       = r_cdone;

`ifdef ARB_ROUND_ROBIN_EN
    logic [c_GW-1:0] r_rr_ptr;

    // Scan from the far end so the client closest to the pointer wins last.
    always_comb begin
        int idx;
        idx     = 0;
        w_grant = '0;
        for (int off = NCLIENT - 1; off >= 0; off--) begin
            idx = int'(r_rr_ptr) + off;
            if (idx >= NCLIENT) begin
                idx = idx - NCLIENT;
            end
            if (bus.creq[idx[c_GW-1:0]]) begin
                w_grant = idx[c_GW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_rr_ptr <= (w_grant == c_GW'(NCLIENT - 1)) ? '0 : w_grant + 1'b1;
        end
    end
`else
    always_comb begin
        w_grant = '0;
        for (int i = NCLIENT - 1; i >= 0; i--) begin
            if (bus.creq[c_GW'(i)]) begin
                w_grant = c_GW'(i);
            end
        end
    end
`endif

    always_comb begin
        w_rbuf_next             = r_rbuf;
        w_rbuf_next[w_beat_idx] = bus.bus_resp;
    end

    // Bus outputs are registered from the current state, so they lag the
    // state register by one cycle on entry to ADDR.
    always_comb begin
        w_state_next      = r_state;
        w_beat_next       = r_beat;
        w_bus_reqcyc_next = 1'b0;
        w_bus_req_next    = '0;
        w_bus_reqtag_next = '0;
        w_cdone_next      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next = S_ADDR;
                    w_beat_next  = '0;
                end
            end
            S_ADDR: begin
                w_bus_reqcyc_next = 1'b1;
                w_bus_req_next    = BUS_BITS'(r_addr);
                w_bus_reqtag_next = w_tag;
                if (w_req_fire) begin
                    if (r_wr) begin
                        w_state_next   = S_WDATA;
                        w_bus_req_next = r_wbuf[0];
                        w_beat_next    = c_CW'(1);
                    end else begin
                        w_state_next      = S_RWAIT;
                        w_bus_reqcyc_next = 1'b0;
                        w_bus_req_next    = '0;
                        w_bus_reqtag_next = '0;
                        w_beat_next       = '0;
                    end
                end
            end
            S_WDATA: begin
                if (r_beat < c_BEATS) begin
                    w_bus_reqcyc_next = 1'b1;
                    w_bus_req_next    = r_wbuf[w_beat_idx];
                    w_bus_reqtag_next = w_tag;
                    w_beat_next       = r_beat + 1'b1;
                end else begin
                    w_state_next = S_DONE;
                    w_cdone_next = w_grant_onehot;
                end
            end
            S_RWAIT: begin
                if (w_beat_take) begin
                    w_beat_next = r_beat + 1'b1;
                    if (w_line_done) begin
                        w_state_next = S_DONE;
                        w_cdone_next = w_grant_onehot;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_grant      <= '0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wbuf       <= '0;
            r_rbuf       <= '0;
            r_crdata     <= '0;
            r_bus_reqcyc <= 1'b0;
            r_bus_req    <= '0;
            r_bus_reqtag <= '0;
            r_cdone      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_beat       <= w_beat_next;
            r_bus_reqcyc <= w_bus_reqcyc_next;
            r_bus_req    <= w_bus_req_next;
            r_bus_reqtag <= w_bus_reqtag_next;
            r_cdone      <= w_cdone_next;
            if (r_state == S_IDLE && w_any_req) begin
                r_grant <= w_grant;
                r_wr    <= bus.cwr[w_grant];
                r_addr  <= w_caddr_arr[w_grant];
                r_wbuf  <= w_cwdata_arr[w_grant];
            end
            if (w_beat_take) begin
                r_rbuf <= w_rbuf_next;
            end
            if (w_line_done) begin
                r_crdata <= w_rbuf_next;
            end
        end
    end
endmodule
`default_nettype wire
